vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen_if.sv | 20 ++
 rtl/vga_sync_gen.sv | 80 ++++++++
 tb/tb_vga_sync_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle produced by vga_sync_gen: syncs, scope probes, raster position and strobes.
interface vga_sync_gen_if;
  logic       HS;
  logic       VS;
  logic       HS_probe;
  logic       VS_probe;
  logic [9:0] x;
  logic [9:0] y;
  logic       VIDEO_ON;
  logic       PIXEL_TICK;
  logic       FRAME_START;

  modport master (
    output HS, VS, HS_probe, VS_probe, x, y, VIDEO_ON, PIXEL_TICK, FRAME_START
  );

  modport slave (
    input HS, VS, HS_probe, VS_probe, x, y, VIDEO_ON, PIXEL_TICK, FRAME_START
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel prescaler, x/y counters, registered active-low syncs
// and a one-cycle frame-start strobe.
module vga_sync_gen #(
  parameter int DIV    = 4,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic            CLK,
  input  logic            RST,
  vga_sync_gen_if.master  vga
);

  localparam int PW = $clog2(DIV);

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);

  logic [PW-1:0] pre_q;
  logic [9:0]    x_q, y_q, x_n, y_n;
  logic          hs_q, vs_q, fs_q;
  logic          tick;

  assign tick = (pre_q == PRE_MAX);

  always_comb begin
    x_n = x_q;
    y_n = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_n = '0;
        y_n = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_n = x_q + 10'd1;
      end
    end
  end

  // Syncs are registered from the next-state counters so they switch on the same edge as x/y.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      x_q   <= x_n;
      y_q   <= y_n;
      hs_q  <= !((x_n >= HS_BEG) && (x_n <= HS_END));
      vs_q  <= !((y_n >= VS_BEG) && (y_n <= VS_END));
      fs_q  <= tick && (x_q == H_LAST) && (y_q == V_LAST);
    end
  end

  assign vga.HS          = hs_q;
  assign vga.VS          = vs_q;
  assign vga.HS_probe    = hs_q;
  assign vga.VS_probe    = vs_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.VIDEO_ON    = (x_q < H_VIS_L) && (y_q < V_VIS_L);
  assign vga.PIXEL_TICK  = tick;
  assign vga.FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for pixel/line timing, a shrunken instance for
// frame-level behaviour and mid-frame reset.
module tb_vga_sync_gen;

  logic CLK = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  vga_sync_gen_if dif ();
  vga_sync_gen_if sif ();

  vga_sync_gen u_dflt (
    .CLK (CLK),
    .RST (rst_d),
    .vga (dif)
  );

  // 15 px x 8 lines, 2 CLK per pixel: HS low x=10..12, VS low y=5..6, 240 CLK per frame.
  vga_sync_gen #(
    .DIV    (2),
    .H_VIS  (8),
    .H_FP   (2),
    .H_SYNC (3),
    .H_BP   (2),
    .V_VIS  (4),
    .V_FP   (1),
    .V_SYNC (2),
    .V_BP   (1)
  ) u_small (
    .CLK (CLK),
    .RST (rst_s),
    .vga (sif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int fall1, fall2, rise1, xf, xr, xmax, ymax, probe_bad;
    int epre, ex, ey, trace_bad, fs_n, vs_low, vid_px, wraps, wrap_bad, waited;
    int fs_k[3];
    logic etick, efs, prev_hs, wrap_pend;

    repeat (3) @(negedge CLK);
    #1;
    check("rst_x",        dif.x, 0);
    check("rst_y",        dif.y, 0);
    check("rst_hs",       dif.HS, 1);
    check("rst_vs",       dif.VS, 1);
    check("rst_hs_probe", dif.HS_probe, 1);
    check("rst_vs_probe", dif.VS_probe, 1);
    check("rst_tick",     dif.PIXEL_TICK, 0);
    check("rst_fs",       dif.FRAME_START, 0);
    check("rst_video_on", dif.VIDEO_ON, 1);

    // Default instance: first pixel ticks after release.
    @(negedge CLK);
    rst_d = 1'b0;
    #1;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("tick_c%0d", k), dif.PIXEL_TICK, (k % 4 == 0) ? 1 : 0);
      check($sformatf("x_c%0d", k), dif.x, (k - 1) / 4);
      @(negedge CLK);
      #1;
    end

    // One-plus lines of free run: HS edges, pulse width and line period.
    fall1 = -1; fall2 = -1; rise1 = -1; xf = -1; xr = -1; xmax = 0; probe_bad = 0;
    prev_hs = dif.HS;
    for (int k = 13; k <= 7000; k++) begin
      if (prev_hs && !dif.HS) begin
        if (fall1 < 0) begin fall1 = k; xf = dif.x; end
        else if (fall2 < 0) fall2 = k;
      end
      if (!prev_hs && dif.HS && fall1 >= 0 && rise1 < 0) begin
        rise1 = k;
        xr = dif.x;
      end
      if (dif.HS_probe !== dif.HS || dif.VS_probe !== dif.VS) probe_bad++;
      if (int'(dif.x) > xmax) xmax = dif.x;
      prev_hs = dif.HS;
      if (k == 7000) begin
        check("x_at_7000", dif.x, 149);
        check("y_at_7000", dif.y, 2);
      end else begin
        @(negedge CLK);
        #1;
      end
    end
    check("hs_fall_x",     xf, 656);
    check("hs_rise_x",     xr, 752);
    check("hs_low_clk",    rise1 - fall1, 384);
    check("line_period",   fall2 - fall1, 3200);
    check("probe_mirror",  probe_bad, 0);
    check("x_max_dflt",    xmax, 799);

    // Small instance: three frames against a cycle model.
    @(negedge CLK);
    rst_s = 1'b0;
    #1;
    epre = 0; ex = 0; ey = 0; efs = 1'b0;
    trace_bad = 0; fs_n = 0; vs_low = 0; vid_px = 0; wraps = 0; wrap_bad = 0;
    xmax = 0; ymax = 0; wrap_pend = 1'b0;
    for (int k = 1; k <= 730; k++) begin
      if (sif.x !== 10'(ex) || sif.y !== 10'(ey) ||
          sif.PIXEL_TICK !== (epre == 1) ||
          sif.HS !== !(ex >= 10 && ex <= 12) ||
          sif.VS !== !(ey >= 5 && ey <= 6) ||
          sif.HS_probe !== sif.HS || sif.VS_probe !== sif.VS ||
          sif.FRAME_START !== efs ||
          sif.VIDEO_ON !== (ex < 8 && ey < 4))
        trace_bad++;
      if (wrap_pend && (sif.x !== 10'd0 || sif.y !== 10'd0)) wrap_bad++;
      wrap_pend = sif.PIXEL_TICK && sif.x == 10'd14 && sif.y == 10'd7;
      if (wrap_pend) wraps++;
      if (sif.FRAME_START) begin
        if (fs_n < 3) fs_k[fs_n] = k;
        fs_n++;
        check($sformatf("fs_xy_%0d", fs_n), {sif.x, sif.y}, 0);
      end
      if (k >= 241 && k <= 480) begin
        if (!sif.VS) vs_low++;
        if (sif.PIXEL_TICK && sif.VIDEO_ON) vid_px++;
      end
      if (int'(sif.x) > xmax) xmax = sif.x;
      if (int'(sif.y) > ymax) ymax = sif.y;

      etick = (epre == 1);
      efs   = etick && ex == 14 && ey == 7;
      if (etick) begin
        if (ex == 14) begin
          ex = 0;
          ey = (ey == 7) ? 0 : ey + 1;
        end else begin
          ex = ex + 1;
        end
      end
      epre = etick ? 0 : epre + 1;
      @(negedge CLK);
      #1;
    end
    check("small_trace",   trace_bad, 0);
    check("fs_count",      fs_n, 3);
    check("fs_first_k",    fs_k[0], 241);
    check("frame_period1", fs_k[1] - fs_k[0], 240);
    check("frame_period2", fs_k[2] - fs_k[1], 240);
    check("vs_low_clk",    vs_low, 60);
    check("video_px",      vid_px, 32);
    check("wrap_count",    wraps, 3);
    check("wrap_same_edge", wrap_bad, 0);
    check("x_max_small",   xmax, 14);
    check("y_max_small",   ymax, 7);

    // Mid-frame reset while both syncs are low.
    waited = 0;
    while (!(sif.x == 10'd11 && sif.y == 10'd5) && waited < 300) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    check("midrst_reached", (waited < 300) ? 1 : 0, 1);
    check("pre_rst_hs", sif.HS, 0);
    check("pre_rst_vs", sif.VS, 0);
    #1;
    rst_s = 1'b1;
    #1;
    check("midrst_x",  sif.x, 0);
    check("midrst_y",  sif.y, 0);
    check("midrst_hs", sif.HS, 1);
    check("midrst_vs", sif.VS, 1);
    check("midrst_hs_probe", sif.HS_probe, 1);
    check("midrst_vs_probe", sif.VS_probe, 1);
    check("midrst_tick", sif.PIXEL_TICK, 0);
    check("midrst_fs",   sif.FRAME_START, 0);
    repeat (2) @(negedge CLK);
    rst_s = 1'b0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("restart_tick_c%0d", k), sif.PIXEL_TICK, (k % 2 == 0) ? 1 : 0);
      check($sformatf("restart_x_c%0d", k), sif.x, (k - 1) / 2);
      @(negedge CLK);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
